// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-scheduler signal bundle
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic       ex_valid;
    logic       ex_regwrite;
    logic       ex_memread;
    logic       ex_muldiv;
    logic       ex_redirect;
    logic [4:0] ex_dst;
    logic       mem_valid;
    logic       mem_regwrite;
    logic [4:0] mem_dst;
    logic       wb_valid;
    logic       wb_regwrite;
    logic [4:0] wb_dst;
    logic       dmem_req;
    logic       dmem_ack;
    logic [1:0] fwd_rs1_sel;
    logic [1:0] fwd_rs2_sel;
    logic       stall_if;
    logic       stall_id;
    logic       stall_ex;
    logic       stall_mem;
    logic       bubble_ex;
    logic       bubble_mem;
    logic       bubble_wb;
    logic       flush_if_id;

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_valid, ex_regwrite, ex_memread, ex_muldiv, ex_redirect, ex_dst,
        input  mem_valid, mem_regwrite, mem_dst,
        input  wb_valid, wb_regwrite, wb_dst,
        input  dmem_req, dmem_ack,
        output fwd_rs1_sel, fwd_rs2_sel,
        output stall_if, stall_id, stall_ex, stall_mem,
        output bubble_ex, bubble_mem, bubble_wb, flush_if_id
    );

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_valid, ex_regwrite, ex_memread, ex_muldiv, ex_redirect, ex_dst,
        output mem_valid, mem_regwrite, mem_dst,
        output wb_valid, wb_regwrite, wb_dst,
        output dmem_req, dmem_ack,
        input  fwd_rs1_sel, fwd_rs2_sel,
        input  stall_if, stall_id, stall_ex, stall_mem,
        input  bubble_ex, bubble_mem, bubble_wb, flush_if_id
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall, bubble and flush scheduler for the 5-stage pipeline
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 3
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        MDBUSY  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic load_use;
    logic [1:0] sel1, sel2;

    always_comb begin
        ex_m1  = hz.ex_valid  && hz.ex_regwrite  && (hz.ex_dst  == hz.id_rs1) && (hz.id_rs1 != 5'd0) && hz.id_rs1_used;
        ex_m2  = hz.ex_valid  && hz.ex_regwrite  && (hz.ex_dst  == hz.id_rs2) && (hz.id_rs2 != 5'd0) && hz.id_rs2_used;
        mem_m1 = hz.mem_valid && hz.mem_regwrite && (hz.mem_dst == hz.id_rs1) && (hz.id_rs1 != 5'd0) && hz.id_rs1_used;
        mem_m2 = hz.mem_valid && hz.mem_regwrite && (hz.mem_dst == hz.id_rs2) && (hz.id_rs2 != 5'd0) && hz.id_rs2_used;
        wb_m1  = hz.wb_valid  && hz.wb_regwrite  && (hz.wb_dst  == hz.id_rs1) && (hz.id_rs1 != 5'd0) && hz.id_rs1_used;
        wb_m2  = hz.wb_valid  && hz.wb_regwrite  && (hz.wb_dst  == hz.id_rs2) && (hz.id_rs2 != 5'd0) && hz.id_rs2_used;
        sel1 = ex_m1 ? 2'd1 : mem_m1 ? 2'd2 : wb_m1 ? 2'd3 : 2'd0;
        sel2 = ex_m2 ? 2'd1 : mem_m2 ? 2'd2 : wb_m2 ? 2'd3 : 2'd0;
        load_use = hz.ex_memread && (ex_m1 || ex_m2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The memory-ack cycle of MEMWAIT unfreezes EX, so it takes the same
    // mul/div-start, redirect and load-use decisions as a RUN cycle.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        hz.fwd_rs1_sel = 2'd0;
        hz.fwd_rs2_sel = 2'd0;
        hz.stall_if    = 1'b0;
        hz.stall_id    = 1'b0;
        hz.stall_ex    = 1'b0;
        hz.stall_mem   = 1'b0;
        hz.bubble_ex   = 1'b0;
        hz.bubble_mem  = 1'b0;
        hz.bubble_wb   = 1'b0;
        hz.flush_if_id = 1'b0;
        if (!reset) begin
            hz.fwd_rs1_sel = sel1;
            hz.fwd_rs2_sel = sel2;
            if (state == MDBUSY) begin
                hz.stall_if   = 1'b1;
                hz.stall_id   = 1'b1;
                hz.stall_ex   = 1'b1;
                hz.bubble_mem = 1'b1;
                cnt_n         = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1))
                    state_n = RUN;
            end else if ((state == MEMWAIT && !hz.dmem_ack) ||
                         (state == RUN && hz.dmem_req && !hz.dmem_ack)) begin
                hz.stall_if  = 1'b1;
                hz.stall_id  = 1'b1;
                hz.stall_ex  = 1'b1;
                hz.stall_mem = 1'b1;
                hz.bubble_wb = 1'b1;
                state_n      = MEMWAIT;
            end else begin
                state_n = RUN;
                if (hz.ex_valid && hz.ex_muldiv) begin
                    hz.stall_if   = 1'b1;
                    hz.stall_id   = 1'b1;
                    hz.stall_ex   = 1'b1;
                    hz.bubble_mem = 1'b1;
                    cnt_n         = CNT_W'(MULDIV_LAT - 1);
                    if (MULDIV_LAT > 1)
                        state_n = MDBUSY;
                end else if (hz.ex_redirect) begin
                    hz.flush_if_id = 1'b1;
                    hz.bubble_ex   = 1'b1;
                end else if (load_use) begin
                    hz.stall_if  = 1'b1;
                    hz.stall_id  = 1'b1;
                    hz.bubble_ex = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb, flush_if_id}
    logic [7:0] ctl;
    assign ctl = {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                  hz.bubble_ex, hz.bubble_mem, hz.bubble_wb, hz.flush_if_id};

    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_LDUSE  = 8'b1100_1000;
    localparam logic [7:0] C_FREEZE = 8'b1111_0010;
    localparam logic [7:0] C_MD     = 8'b1110_0100;
    localparam logic [7:0] C_REDIR  = 8'b0000_1001;

    task automatic clear_inputs;
        hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
        hz.ex_valid = 1'b0; hz.ex_regwrite = 1'b0; hz.ex_memread = 1'b0;
        hz.ex_muldiv = 1'b0; hz.ex_redirect = 1'b0; hz.ex_dst = 5'd0;
        hz.mem_valid = 1'b0; hz.mem_regwrite = 1'b0; hz.mem_dst = 5'd0;
        hz.wb_valid = 1'b0; hz.wb_regwrite = 1'b0; hz.wb_dst = 5'd0;
        hz.dmem_req = 1'b0; hz.dmem_ack = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_inputs();
        hz.id_rs1 = 5'd5; hz.id_rs1_used = 1'b1;
        hz.ex_valid = 1'b1; hz.ex_regwrite = 1'b1; hz.ex_dst = 5'd5; hz.ex_muldiv = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE); end
        n_tests++;
        if (hz.fwd_rs1_sel !== 2'd0) begin n_fail++; $display("FAIL reset_fwd: got %0d want 0", hz.fwd_rs1_sel); end
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL reset_release: got %b want %b", ctl, C_NONE); end
    endtask

    task automatic test_forward;
        @(negedge clk);
        clear_inputs();
        hz.id_rs1 = 5'd5; hz.id_rs1_used = 1'b1;
        hz.ex_valid = 1'b1; hz.ex_regwrite = 1'b1; hz.ex_dst = 5'd5;
        hz.mem_valid = 1'b1; hz.mem_regwrite = 1'b1; hz.mem_dst = 5'd5;
        #1;
        n_tests++;
        if (hz.fwd_rs1_sel !== 2'd1) begin n_fail++; $display("FAIL fwd_ex_prio: got %0d want 1", hz.fwd_rs1_sel); end
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL fwd_no_stall: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        hz.ex_regwrite = 1'b0;
        #1;
        n_tests++;
        if (hz.fwd_rs1_sel !== 2'd2) begin n_fail++; $display("FAIL fwd_mem: got %0d want 2", hz.fwd_rs1_sel); end
        @(negedge clk);
        clear_inputs();
        hz.id_rs1 = 5'd0; hz.id_rs1_used = 1'b1;
        hz.ex_valid = 1'b1; hz.ex_regwrite = 1'b1; hz.ex_dst = 5'd0;
        hz.id_rs2 = 5'd9; hz.id_rs2_used = 1'b1;
        hz.wb_valid = 1'b1; hz.wb_regwrite = 1'b1; hz.wb_dst = 5'd9;
        #1;
        n_tests++;
        if (hz.fwd_rs1_sel !== 2'd0) begin n_fail++; $display("FAIL fwd_x0: got %0d want 0", hz.fwd_rs1_sel); end
        n_tests++;
        if (hz.fwd_rs2_sel !== 2'd3) begin n_fail++; $display("FAIL fwd_wb: got %0d want 3", hz.fwd_rs2_sel); end
        @(negedge clk);
        hz.id_rs2_used = 1'b0;
        #1;
        n_tests++;
        if (hz.fwd_rs2_sel !== 2'd0) begin n_fail++; $display("FAIL fwd_unused: got %0d want 0", hz.fwd_rs2_sel); end
    endtask

    task automatic test_load_use;
        @(negedge clk);
        clear_inputs();
        hz.id_rs2 = 5'd7; hz.id_rs2_used = 1'b1;
        hz.ex_valid = 1'b1; hz.ex_regwrite = 1'b1; hz.ex_memread = 1'b1; hz.ex_dst = 5'd7;
        #1;
        n_tests++;
        if (ctl !== C_LDUSE) begin n_fail++; $display("FAIL ld_use_stall: got %b want %b", ctl, C_LDUSE); end
        @(negedge clk);
        clear_inputs();
        hz.id_rs2 = 5'd7; hz.id_rs2_used = 1'b1;
        hz.mem_valid = 1'b1; hz.mem_regwrite = 1'b1; hz.mem_dst = 5'd7;
        #1;
        n_tests++;
        if (hz.fwd_rs2_sel !== 2'd2) begin n_fail++; $display("FAIL ld_use_fwd: got %0d want 2", hz.fwd_rs2_sel); end
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL ld_use_release: got %b want %b", ctl, C_NONE); end
    endtask

    task automatic test_redirect_over_load_use;
        @(negedge clk);
        clear_inputs();
        hz.id_rs1 = 5'd3; hz.id_rs1_used = 1'b1;
        hz.ex_valid = 1'b1; hz.ex_regwrite = 1'b1; hz.ex_memread = 1'b1; hz.ex_dst = 5'd3;
        hz.ex_redirect = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_REDIR) begin n_fail++; $display("FAIL redir_vs_lduse: got %b want %b", ctl, C_REDIR); end
    endtask

    task automatic test_muldiv;
        @(negedge clk);
        clear_inputs();
        hz.ex_valid = 1'b1; hz.ex_muldiv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                hz.ex_muldiv = 1'b0;
            end
            #1;
            n_tests++;
            if (ctl !== C_MD) begin n_fail++; $display("FAIL md_hold_%0d: got %b want %b", i, ctl, C_MD); end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL md_release: got %b want %b", ctl, C_NONE); end
    endtask

    task automatic test_memwait;
        @(negedge clk);
        clear_inputs();
        hz.dmem_req = 1'b1;
        hz.ex_valid = 1'b1; hz.ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_tests++;
            if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL mw_freeze_%0d: got %b want %b", i, ctl, C_FREEZE); end
        end
        @(negedge clk);
        hz.dmem_ack = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_REDIR) begin n_fail++; $display("FAIL mw_ack_redirect: got %b want %b", ctl, C_REDIR); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL mw_after: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        hz.dmem_req = 1'b1; hz.dmem_ack = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL mw_req_ack_same: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL mw_stay_run: got %b want %b", ctl, C_NONE); end
    endtask

    task automatic test_reset_in_mdbusy;
        @(negedge clk);
        clear_inputs();
        hz.ex_valid = 1'b1; hz.ex_muldiv = 1'b1;
        @(negedge clk);
        hz.ex_muldiv = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL mdr_in_reset: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL mdr_after_reset: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL mdr_no_residual: got %b want %b", ctl, C_NONE); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_redirect_over_load_use();
        test_muldiv();
        test_memwait();
        test_reset_in_mdbusy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
